// File: rtl/berger_mem_ctrl_pkg.sv
// Shared types and constants for the Berger-coded memory controller slice.
// Holds the sequencer state encoding and the response/error encodings.
package berger_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_RCHK = 3'd3,
        ST_RESP = 3'd4,
        ST_SRD  = 3'd5,
        ST_SCHK = 3'd6
    } state_t;

    localparam int DEF_ADDR_W = 4;
    localparam int MEM_DEPTH  = 2 ** DEF_ADDR_W;

    // Retry counter is sized for MAX_RETRY up to 7.
    localparam int RETRY_W = 3;

    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

endpackage

// File: rtl/berger_scrub_sched.sv
// Background scrub scheduler: idle-cycle timer plus a wrapping address pointer.
// The timer only advances on idle controller cycles, so host traffic delays scrubbing.
module berger_scrub_sched
    import berger_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 4,
    parameter int SCRUB_INTERVAL = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scrub_en,
    input  logic              idle_tick,
    input  logic              advance,
    output logic              scrub_req,
    output logic [ADDR_W-1:0] scrub_addr
);

    localparam int TMR_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCRUB_INTERVAL - 1);

    logic [TMR_W-1:0]  timer;
    logic [ADDR_W-1:0] ptr;

    assign scrub_req  = idle_tick && scrub_en && (timer == TMR_LAST);
    assign scrub_addr = ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
            ptr   <= '0;
        end else begin
            if (idle_tick) begin
                if (!scrub_en || (timer == TMR_LAST)) begin
                    timer <= '0;
                end else begin
                    timer <= timer + TMR_W'(1);
                end
            end
            // Power-of-two depth, so the natural overflow is the wrap to 0.
            if (advance) begin
                ptr <= ptr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/berger_mem_ctrl.sv
// Sequencing controller for the Berger-coded memory datapath: host read/write,
// read retry on check failure, background scrub and persistent-error logging.
module berger_mem_ctrl
    import berger_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 8,
    parameter int MAX_RETRY      = 2,
    parameter int SCRUB_INTERVAL = 64,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    input  logic              scrub_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] last_err_addr,
    output logic              last_err_valid
);

    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t               state, state_nxt;
    logic [RETRY_W-1:0]   retry, retry_nxt;
    logic                 accept;
    logic                 idle_tick;
    logic                 scrub_req;
    logic [ADDR_W-1:0]    scrub_addr;
    logic                 ptr_advance;
    logic                 log_err;
    logic                 rsp_load;
    logic [DATA_W-1:0]    rsp_rdata_nxt;
    logic                 rsp_err_nxt;

    // req_ready is gated by rst so every output reads 0 while reset is held.
    assign req_ready = rst && (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign idle_tick = (state == ST_IDLE) && !accept;
    assign mem_wr_en = (state == ST_WR);
    assign rsp_valid = (state == ST_RESP);

    berger_scrub_sched #(
        .ADDR_W         (ADDR_W),
        .SCRUB_INTERVAL (SCRUB_INTERVAL)
    ) u_scrub_sched (
        .clk        (clk),
        .rst        (rst),
        .scrub_en   (scrub_en),
        .idle_tick  (idle_tick),
        .advance    (ptr_advance),
        .scrub_req  (scrub_req),
        .scrub_addr (scrub_addr)
    );

    always_comb begin
        state_nxt     = state;
        retry_nxt     = retry;
        rsp_load      = 1'b0;
        rsp_rdata_nxt = '0;
        rsp_err_nxt   = RSP_OK;
        log_err       = 1'b0;
        ptr_advance   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = req_we ? ST_WR : ST_RD;
                end else if (scrub_req) begin
                    state_nxt = ST_SRD;
                end
            end
            ST_WR: begin
                state_nxt = ST_RESP;
                rsp_load  = 1'b1;
            end
            ST_RD: state_nxt = ST_RCHK;
            ST_RCHK: begin
                if (mem_err && (retry < RETRY_LIM)) begin
                    retry_nxt = retry + RETRY_W'(1);
                    state_nxt = ST_RD;
                end else begin
                    state_nxt     = ST_RESP;
                    rsp_load      = 1'b1;
                    rsp_rdata_nxt = mem_rdata;
                    rsp_err_nxt   = mem_err ? RSP_ERR : RSP_OK;
                    log_err       = mem_err;
                end
            end
            ST_RESP: begin
                retry_nxt = '0;
                state_nxt = ST_IDLE;
            end
            ST_SRD: state_nxt = ST_SCHK;
            ST_SCHK: begin
                if (mem_err && (retry < RETRY_LIM)) begin
                    retry_nxt = retry + RETRY_W'(1);
                    state_nxt = ST_SRD;
                end else begin
                    log_err     = mem_err;
                    retry_nxt   = '0;
                    ptr_advance = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Registered memory port, response and error log.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            retry          <= '0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            err_count      <= '0;
            last_err_addr  <= '0;
            last_err_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            retry <= retry_nxt;
            if (accept) begin
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
            end else if (scrub_req) begin
                mem_addr <= scrub_addr;
            end
            if (rsp_load) begin
                rsp_rdata <= rsp_rdata_nxt;
                rsp_err   <= rsp_err_nxt;
            end
            // The logged address is the one still on the port during the check.
            if (log_err) begin
                err_count      <= sat_inc(err_count);
                last_err_addr  <= mem_addr;
                last_err_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_berger_mem_ctrl.sv
// Self-checking bench for berger_mem_ctrl: a behavioural memory with fault
// injection drives the controller; expectations come from a reference model.
module tb_berger_mem_ctrl;

    localparam int ADDR_W         = 4;
    localparam int DATA_W         = 8;
    localparam int MAX_RETRY      = 2;
    localparam int SCRUB_INTERVAL = 4;
    localparam int CNT_W          = 8;
    localparam int DEPTH          = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              scrub_en = 1'b0;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_err;
    logic [CNT_W-1:0]  err_count;
    logic [ADDR_W-1:0] last_err_addr;
    logic              last_err_valid;

    // Environment memory (datapath stand-in) and reference model state.
    logic [DATA_W-1:0] env_mem [DEPTH];
    logic              stuck   [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] rdata_q = '0;
    logic              stuck_q = 1'b0;
    logic              force_err = 1'b0;
    int                exp_err_cnt = 0;
    int                n_checks = 0;
    int                n_pass = 0;

    always #5 clk = ~clk;

    berger_mem_ctrl #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .MAX_RETRY      (MAX_RETRY),
        .SCRUB_INTERVAL (SCRUB_INTERVAL),
        .CNT_W          (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .scrub_en       (scrub_en),
        .mem_wr_en      (mem_wr_en),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_err        (mem_err),
        .err_count      (err_count),
        .last_err_addr  (last_err_addr),
        .last_err_valid (last_err_valid)
    );

    // One-cycle read latency memory: address in cycle N, data/err visible in N+1.
    always @(posedge clk) begin
        if (mem_wr_en) env_mem[mem_addr] <= mem_wdata;
        rdata_q <= env_mem[mem_addr];
        stuck_q <= stuck[mem_addr];
    end
    assign mem_rdata = rdata_q;
    assign mem_err   = stuck_q | force_err;

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = 1'b0;
        scrub_en  = 1'b0;
        force_err = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_err_cnt = 0;
    endtask

    // Issue one host request; force_at names the response-wait cycle whose
    // memory sample sees an injected error (-1 = none).
    task automatic host_txn(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata, input int force_at,
                            output int lat, output logic [DATA_W-1:0] rd, output logic er);
        int guard;
        lat = -1;
        rd  = '0;
        er  = 1'b0;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            n_checks++;
            $display("FAIL ready_wait: req_ready never rose within 50 cycles");
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            force_err = (k == force_at);
            if (rsp_valid) begin
                lat = k;
                rd  = rsp_rdata;
                er  = rsp_err;
                break;
            end
            @(negedge clk);
        end
        force_err = 1'b0;
        if (we) ref_mem[addr] = wdata;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, mem_wr_en, mem_addr, mem_wdata,
             err_count, last_err_addr, last_err_valid} !== '0) begin
            $display("FAIL reset_outputs: ready=%b vld=%b err=%b rd=%h we=%b addr=%h wd=%h cnt=%0d lea=%h lev=%b, required all 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata, mem_wr_en, mem_addr, mem_wdata,
                     err_count, last_err_addr, last_err_valid);
        end else n_pass++;
        do_reset();
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL ready_after_reset: got %b required 1", req_ready);
        else n_pass++;
    endtask

    task automatic test_write_read();
        int lat;
        logic [DATA_W-1:0] rd;
        logic er;
        host_txn(1'b1, 4'd3, 8'hA5, -1, lat, rd, er);
        n_checks++;
        if (lat !== 2) $display("FAIL wr_latency: got %0d required 2", lat); else n_pass++;
        n_checks++;
        if ({rd, er} !== 9'h000) $display("FAIL wr_rsp: rdata=%h err=%b required 00/0", rd, er); else n_pass++;
        host_txn(1'b0, 4'd3, 8'h00, -1, lat, rd, er);
        n_checks++;
        if (lat !== 3) $display("FAIL rd_latency: got %0d required 3", lat); else n_pass++;
        n_checks++;
        if ({rd, er} !== {8'hA5, 1'b0}) $display("FAIL rd_data: rdata=%h err=%b required a5/0", rd, er); else n_pass++;
        n_checks++;
        if (err_count !== 8'd0) $display("FAIL rd_err_count: got %0d required 0", err_count); else n_pass++;
    endtask

    task automatic test_retry_transient();
        int lat;
        logic [DATA_W-1:0] rd;
        logic er;
        host_txn(1'b0, 4'd3, 8'h00, 2, lat, rd, er);
        n_checks++;
        if (lat !== 5) $display("FAIL retry_latency: got %0d required 5", lat); else n_pass++;
        n_checks++;
        if ({rd, er} !== {8'hA5, 1'b0}) $display("FAIL retry_data: rdata=%h err=%b required a5/0", rd, er); else n_pass++;
        n_checks++;
        if (err_count !== CNT_W'(exp_err_cnt)) $display("FAIL retry_err_count: got %0d required %0d", err_count, exp_err_cnt);
        else n_pass++;
    endtask

    task automatic test_persistent();
        int lat;
        logic [DATA_W-1:0] rd;
        logic er;
        host_txn(1'b1, 4'd7, 8'h3C, -1, lat, rd, er);
        stuck[7] = 1'b1;
        host_txn(1'b0, 4'd7, 8'h00, -1, lat, rd, er);
        exp_err_cnt++;
        n_checks++;
        if (lat !== 3 + 2 * MAX_RETRY) $display("FAIL perr_latency: got %0d required %0d", lat, 3 + 2 * MAX_RETRY);
        else n_pass++;
        n_checks++;
        if ({rd, er} !== {ref_mem[7], 1'b1}) $display("FAIL perr_rsp: rdata=%h err=%b required %h/1", rd, er, ref_mem[7]);
        else n_pass++;
        n_checks++;
        if ({err_count, last_err_addr, last_err_valid} !== {CNT_W'(exp_err_cnt), 4'd7, 1'b1})
            $display("FAIL perr_log: cnt=%0d addr=%0d valid=%b required %0d/7/1", err_count, last_err_addr, last_err_valid, exp_err_cnt);
        else n_pass++;
        stuck[7] = 1'b0;
    endtask

    task automatic test_random();
        int lat;
        logic [DATA_W-1:0] rd;
        logic er;
        logic we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] exp_rd;
        for (int i = 0; i < 24; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = ADDR_W'($urandom_range(0, DEPTH - 1));
            d  = DATA_W'($urandom);
            exp_rd = we ? '0 : ref_mem[a];
            host_txn(we, a, d, -1, lat, rd, er);
            n_checks++;
            if (lat !== (we ? 2 : 3)) $display("FAIL rand_latency[%0d]: we=%b got %0d required %0d", i, we, lat, we ? 2 : 3);
            else n_pass++;
            n_checks++;
            if ({rd, er} !== {exp_rd, 1'b0})
                $display("FAIL rand_rsp[%0d]: we=%b addr=%0d rdata=%h err=%b required %h/0", i, we, a, rd, er, exp_rd);
            else n_pass++;
        end
        n_checks++;
        if (err_count !== CNT_W'(exp_err_cnt)) $display("FAIL rand_err_count: got %0d required %0d", err_count, exp_err_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_retry();
        int stale;
        stuck[7] = 1'b1;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd7;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, mem_wr_en, mem_addr, mem_wdata,
             err_count, last_err_addr, last_err_valid} !== '0) begin
            $display("FAIL midreset_outputs: ready=%b vld=%b err=%b rd=%h we=%b addr=%h cnt=%0d lev=%b, required all 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata, mem_wr_en, mem_addr, err_count, last_err_valid);
        end else n_pass++;
        stuck[7] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_err_cnt = 0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL midreset_ready: got %b required 1", req_ready); else n_pass++;
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid !== 1'b0) stale++;
            @(negedge clk);
        end
        n_checks++;
        if (stale != 0) $display("FAIL midreset_stale_rsp: %0d rsp_valid cycles, required 0", stale); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat;
        scrub_en = 1'b1;
        for (int g = 0; g < 50 && req_ready; g++) @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0) $display("FAIL hold_scrub_start: req_ready=%b required 0", req_ready); else n_pass++;
        n_checks++;
        if (mem_addr !== 4'd0) $display("FAIL hold_scrub_addr: got %0d required 0", mem_addr); else n_pass++;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd3;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0) $display("FAIL hold_ready_low: got %b required 0", req_ready); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL hold_ready_back: got %b required 1", req_ready); else n_pass++;
        @(negedge clk);
        req_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            if (rsp_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (lat !== 3) $display("FAIL hold_latency: got %0d required 3", lat); else n_pass++;
        n_checks++;
        if ({rsp_rdata, rsp_err} !== {ref_mem[3], 1'b0})
            $display("FAIL hold_data: rdata=%h err=%b required %h/0", rsp_rdata, rsp_err, ref_mem[3]);
        else n_pass++;
        scrub_en = 1'b0;
    endtask

    task automatic test_scrub();
        int  starts;
        int  idle_run;
        int  wr_seen;
        logic prev_ready;
        do_reset();
        stuck[15] = 1'b1;
        scrub_en  = 1'b1;
        starts    = 0;
        idle_run  = 0;
        wr_seen   = 0;
        prev_ready = 1'b1;
        for (int c = 0; c < 2000 && starts < 33; c++) begin
            @(negedge clk);
            if (mem_wr_en) wr_seen++;
            if (prev_ready && !req_ready) begin
                n_checks++;
                if (mem_addr !== ADDR_W'(starts % DEPTH))
                    $display("FAIL scrub_addr[%0d]: got %0d required %0d", starts, mem_addr, starts % DEPTH);
                else n_pass++;
                n_checks++;
                if (err_count !== CNT_W'(starts / DEPTH))
                    $display("FAIL scrub_err_count[%0d]: got %0d required %0d", starts, err_count, starts / DEPTH);
                else n_pass++;
                if (starts > 0) begin
                    n_checks++;
                    if (idle_run != SCRUB_INTERVAL)
                        $display("FAIL scrub_interval[%0d]: got %0d idle cycles required %0d", starts, idle_run, SCRUB_INTERVAL);
                    else n_pass++;
                end
                starts++;
                idle_run = 0;
            end else if (req_ready) begin
                idle_run++;
            end
            prev_ready = req_ready;
        end
        n_checks++;
        if (starts != 33) $display("FAIL scrub_progress: %0d scrub reads seen, required 33", starts); else n_pass++;
        scrub_en = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({err_count, last_err_addr, last_err_valid} !== {8'd2, 4'd15, 1'b1})
            $display("FAIL scrub_log: cnt=%0d addr=%0d valid=%b required 2/15/1", err_count, last_err_addr, last_err_valid);
        else n_pass++;
        n_checks++;
        if (wr_seen != 0) $display("FAIL scrub_no_write: %0d write strobes, required 0", wr_seen); else n_pass++;
        stuck[15] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            env_mem[i] = '0;
            ref_mem[i] = '0;
            stuck[i]   = 1'b0;
        end
        test_reset();
        test_write_read();
        test_retry_transient();
        test_persistent();
        test_random();
        test_reset_mid_retry();
        test_back_to_back();
        test_scrub();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
